pico_mem_bridge: RTL
====================

// Module: pico_mem_bridge
// PURPOSE
//   Bridge between the picorv32 native memory port and the synchronous single-port
//   word SRAM (1-cycle registered read) in design_top.
//   Replaces the hard-wired mem_ready=1: generates a correctly timed mem_ready and
//   returns read data aligned with it.
//   Drives per-byte write enables and decodes out-of-range addresses.
//   Adds optional wait states for latency-tolerance experiments.
// PARAMETERS
//   WORDS        32  SRAM depth in 32-bit words; power of two, >= 2
//   ADDR_W       5   word-address width, = log2(WORDS)
//   WAIT_STATES  0   extra cycles inserted before mem_ready; 0..15
// PORTS
//   clk        in   1       rising-edge clock
//   resetn     in   1       synchronous active-low reset
//   mem_valid  in   1       CPU request valid; held until mem_ready
//   mem_addr   in   32      CPU byte address; bits [1:0] ignored
//   mem_wdata  in   32      CPU write data
//   mem_wstrb  in   4       CPU byte strobes; 0 = read
//   mem_ready  out  1       one-cycle completion pulse
//   mem_rdata  out  32      read data, valid only while mem_ready=1
//   ram_wen    out  4       SRAM byte write enables
//   ram_addr   out  ADDR_W  SRAM word address
//   ram_wdata  out  32      SRAM write data
//   ram_rdata  in   32      SRAM registered read data
//   bus_err    out  1       sticky: out-of-range access has occurred
//   err_addr   out  32      byte address of the first out-of-range access
// BEHAVIOUR
//   Reset (resetn=0 at a clk edge) forces, from the next cycle:
//     state=IDLE, mem_ready=0, mem_rdata=0, ram_wen=0, bus_err=0, err_addr=0.
//   Reset mid-transaction aborts it with no mem_ready.
//   While resetn=0, ram_wen is forced to 0 combinationally.
//   FSM states:
//     IDLE: mem_valid=1 is an accept; latch addr, wstrb and the range flag.
//       WAIT_STATES=0 -> RESP, else -> WAIT with cnt=WAIT_STATES-1.
//     WAIT: cnt==0 -> RESP, else cnt--.
//     RESP: mem_ready=1 for exactly one cycle -> IDLE unconditionally.
//   The CPU drops mem_valid after ready, so IDLE never double-accepts.
//   Range: in_range = (mem_addr[31:ADDR_W+2] == 0).
//   ram_addr = mem_addr[ADDR_W+1:2] in IDLE; latched word address in WAIT/RESP.
//     It stays stable, so ram_rdata is steady through RESP.
//   ram_wdata = mem_wdata, combinational pass-through.
//   ram_wen = mem_wstrb only in the accept cycle and only if in_range; 0 otherwise.
//     Each write lands exactly once.
//   mem_rdata = ram_rdata in RESP when in_range and the access is a read.
//     mem_rdata = 0 in RESP for writes and for out-of-range accesses.
//     mem_rdata = 0 outside RESP.
//   Latency: accept at cycle T -> mem_ready in cycle T+1+WAIT_STATES.
//     Reads and writes have the same latency.
//   Out-of-range accesses:
//     - write suppressed; ready still returned, so the CPU never hangs;
//     - bus_err is set at the accept edge;
//     - err_addr is loaded only if bus_err was 0, so the first error wins.
//   Back-to-back: minimum spacing between accepts is 2+WAIT_STATES cycles.
//   Highest word (addr = 4*(WORDS-1)) is in range; 4*WORDS is out of range.
//     No wrap-around aliasing.
// STRUCTURE
//   Shared package pico_mem_pkg:
//     - state localparams ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2;
//     - ADDR_LSB=2.
//   Single module, no sub-module.
//   The SRAM (picosoc_mem) stays instantiated beside the bridge in design_top.
// TESTING
//   1. Reset: resetn=0 for 2 cycles with mem_valid=1
//      -> mem_ready=0, ram_wen=0, bus_err=0 throughout.
//   2. Write then read (WAIT_STATES=0):
//      - write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> ram_wen=F for 1 cycle,
//        ready at T+1;
//      - read 0x10 -> ready at T+1 with mem_rdata=0xDEADBEEF.
//   3. Byte strobe: write 0x11223344 to 0x08, then wdata 0x000000AA with wstrb 4'h1
//      -> read 0x08 returns 0x112233AA.
//   4. Out of range (WORDS=32): write to 0x80 -> ram_wen stays 0, ready at T+1,
//      bus_err=1, err_addr=0x80; then access 0x84 -> err_addr stays 0x80;
//      read 0x7C succeeds.
//   5. WAIT_STATES=3: read accepted at T -> mem_ready only in T+4;
//      ram_addr constant T..T+4.
//   6. Abort: resetn=0 during WAIT -> no mem_ready; a fresh read afterwards
//      completes normally.

Source files
------------

// File: rtl/pico_mem_pkg.sv
// Shared definitions for the picorv32 native-port to single-port SRAM bridge.
// Holds the FSM encoding, the byte-to-word address offset and the range check.
package pico_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int ADDR_LSB = 2;

  // Any set bit above the word-address field is out of range, so there is no aliasing.
  function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
    return (addr >> (addr_w + ADDR_LSB)) == 32'd0;
  endfunction

endpackage

// File: rtl/pico_mem_bridge_if.sv
// picorv32 native memory port, bundled so that the CPU side and the bridge side
// can be connected as a single port.
interface pico_mem_bridge_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/pico_mem_bridge.sv
// Bridge between the picorv32 native memory port and a 1-cycle registered-read word SRAM:
// timed mem_ready, aligned read data, byte write enables, range decode and wait states.
module pico_mem_bridge
  import pico_mem_pkg::*;
#(
  parameter int WORDS       = 32,
  parameter int ADDR_W      = 5,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  pico_mem_bridge_if.slave  cpu,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              bus_err,
  output logic [31:0]       err_addr
);

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic [ADDR_W-1:0]   waddr_reg;
  logic                rd_ok_reg;
  logic                ready_reg;
  logic                bus_err_reg;
  logic [31:0]         err_addr_reg;

  logic                accept;
  logic                in_range;
  logic [ADDR_W-1:0]   cpu_waddr;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  assign in_range  = addr_in_range(cpu.mem_addr, ADDR_W) && (WORDS == (1 << ADDR_W));
  assign accept    = (state_reg == ST_IDLE) && cpu.mem_valid;
  assign cpu_waddr = cpu.mem_addr[ADDR_W+ADDR_LSB-1:ADDR_LSB];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      waddr_reg    <= '0;
      rd_ok_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      bus_err_reg  <= 1'b0;
      err_addr_reg <= 32'd0;
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cpu.mem_valid) begin
            waddr_reg <= cpu_waddr;
            rd_ok_reg <= in_range && (cpu.mem_wstrb == 4'h0);
            if (!in_range) begin
              bus_err_reg <= 1'b1;
              if (!bus_err_reg) begin
                err_addr_reg <= cpu.mem_addr;
              end
            end
            if (WAIT_STATES == 0) begin
              state_reg <= ST_RESP;
              ready_reg <= 1'b1;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= ST_RESP;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // The address is held after accept so the SRAM keeps re-reading the same word through RESP.
  assign ram_addr  = (state_reg == ST_IDLE) ? cpu_waddr : waddr_reg;
  assign ram_wdata = cpu.mem_wdata;
  assign ram_wen   = (resetn && accept && in_range) ? cpu.mem_wstrb : 4'h0;

  assign cpu.mem_ready = ready_reg;
  assign cpu.mem_rdata = (ready_reg && rd_ok_reg) ? ram_rdata : 32'd0;

  assign bus_err  = bus_err_reg;
  assign err_addr = err_addr_reg;

endmodule
